cpu_result_monitor: RTL and testbench
=====================================

Name: cpu_result_monitor

Overview:
- Parametrised, synthesisable run monitor for the single-cycle CPU.
- Captures each valid ALU result into a trace buffer and compares it with a preloaded expected-value table.
- Counts mismatches and cycles, and flags pass, fail or timeout.
- Sits beside the CPU in the top level and bench. Replaces free-running, unchecked clock/reset stimulus with an on-chip checked run.

Parameters:
- DATA_W, 16, width of the ALU result and expected values.
- DEPTH, 16, number of expected/trace entries; power of two, at least 2.
- IDX_W, $clog2(DEPTH), index width.
- CYC_W, 16, cycle-counter width.
- MAX_CYCLES, 1000, timeout in RUN cycles; must be less than 2^CYC_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a run from IDLE or DONE.
- exp_count  in  IDX_W+1  number of results expected; sampled on start; legal range 1..DEPTH.
- exp_wr_en  in  1  write enable into the expected table.
- exp_wr_addr  in  IDX_W  expected-table write address.
- exp_wr_data  in  DATA_W  expected value.
- sample_valid  in  1  the ALU result is valid this cycle.
- sample_data  in  DATA_W  ALU result (CPU alu_out).
- trace_rd_addr  in  IDX_W  trace-buffer read address.
- trace_rd_data  out  DATA_W  trace entry; registered, 1-cycle read latency.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  done, no mismatches, no timeout.
- timeout  out  1  run ended because MAX_CYCLES was reached.
- mismatch_count  out  IDX_W+1  number of compare failures.
- first_fail_idx  out  IDX_W  index of the first mismatch; valid when mismatch_count is non-zero.
- cycle_count  out  CYC_W  number of cycles spent in RUN.

Behaviour:
- Reset values: all outputs are 0; the state is IDLE; the internal sample index is 0.
- Table and trace contents are not cleared by reset.
- States:
  - IDLE: waits for start. On start, latch exp_count, clear the counters, index and flags, and go to RUN.
  - RUN: busy=1. cycle_count increments every cycle.
    - On sample_valid, write sample_data to trace[idx] and compare it with exp[idx].
    - On a compare failure, mismatch_count increments. If this is the first failure, first_fail_idx takes idx.
    - After the compare, idx increments.
    - When the accepted sample is number exp_count (idx = exp_count-1), go to DONE on the next edge.
    - If cycle_count reaches MAX_CYCLES-1 without the final sample, set timeout=1 and go to DONE.
  - DONE: done=1, and pass = (mismatch_count==0 && !timeout). All results hold until start, which restarts exactly as from IDLE.
- Latency: mismatch_count, first_fail_idx and idx update on the edge that accepts the sample. done asserts on the following edge.
- Simultaneous events:
  - Final sample and timeout in the same cycle: the sample is accepted and compared, and timeout stays 0.
  - sample_valid outside RUN is ignored.
  - start during RUN is ignored.
  - exp_wr_en during RUN is ignored. In IDLE and DONE it writes the table.
  - Read and write of the same trace address in one cycle: the read returns the old data.
- Arithmetic: all counters are unsigned and saturate; they never wrap. mismatch_count cannot exceed exp_count. exp_count=0 is treated as 1.
- Reset mid-run: immediately returns to IDLE with all outputs at 0. Partially written trace entries remain.

Optional Feature:
- Macro: MONITOR_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the run. The state goes to DONE on the next edge, pass=0, mismatch_count=1, and no further samples are accepted.
- Undefined: the run always continues to exp_count samples or to the timeout.

Decomposition:
- Shared package cpu_monitor_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default constants DATA_W, DEPTH and MAX_CYCLES;
  - a saturating-increment function.
- One sub-module, monitor_ram: a simple dual-port RAM with synchronous read and synchronous write, parametrised by width and depth. It is instantiated twice, once for the expected table and once for the trace buffer.

Test Plan:
- Load exp = {5, 10, 15, 20}, exp_count=4, start, then drive samples 5, 10, 15, 20 with gaps → done=1, pass=1, mismatch_count=0, cycle_count equals the RUN cycles; trace_rd_addr=2 gives 15 after 1 cycle.
- Same table, samples 5, 11, 15, 19 → pass=0, mismatch_count=2, first_fail_idx=1. With MONITOR_STOP_ON_FAIL_EN: done after the 2nd sample, mismatch_count=1.
- exp_count=4, only 2 samples, MAX_CYCLES=1000 → timeout=1 at cycle_count=999, done=1, pass=0.
- Assert reset mid-run after 2 samples → all outputs 0 asynchronously. A new start and 4 correct samples → pass=1.
- Final sample on the timeout cycle → timeout=0, pass=1. sample_valid in IDLE and exp_wr_en during RUN have no effect, checked by reading the trace and the table.
- DEPTH=16, exp_count=16, all samples equal 0xFFFF and all expected equal 0xFFFF → pass=1, and the index does not wrap.

Source files
------------

// File: rtl/cpu_monitor_pkg.sv
// Shared types and defaults for the CPU result monitor.
package cpu_monitor_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_MAX_CYCLES = 1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mon_state_e;

  // Increment that sticks at i_max instead of wrapping; callers cast to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] i_val, input logic [31:0] i_max);
    return (i_val >= i_max) ? i_max : i_val + 32'd1;
  endfunction

endpackage

// File: rtl/monitor_ram.sv
// Simple dual-port RAM: synchronous write, registered read (read-before-write on
// a same-address collision). Array contents are never reset; only the read
// register is, so the read port shows 0 while reset is asserted.
module monitor_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read port, one cycle of latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rd_data <= '0;
    else       r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cpu_result_monitor.sv
// Run monitor for the single-cycle CPU: traces each valid ALU result, compares it
// with a preloaded expected table, and reports pass / fail / timeout.
// Optional build macro MONITOR_STOP_ON_FAIL_EN: the first mismatch ends the run.
//
// state   | meaning
// IDLE    | after reset, waiting for start; expected table writable
// RUN     | counting cycles, accepting and comparing samples
// DONE    | results held; table writable; start begins a new run
module cpu_result_monitor
  import cpu_monitor_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int IDX_W      = $clog2(DEPTH),
  parameter int CYC_W      = 16,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W:0]    exp_count,
  input  logic              exp_wr_en,
  input  logic [IDX_W-1:0]  exp_wr_addr,
  input  logic [DATA_W-1:0] exp_wr_data,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [IDX_W-1:0]  trace_rd_addr,
  output logic [DATA_W-1:0] trace_rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [IDX_W:0]    mismatch_count,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic [CYC_W-1:0]  cycle_count
);

  localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   CNT_DEPTH = (IDX_W+1)'(DEPTH);
  localparam logic [CYC_W-1:0] CYC_MAX   = '1;
  localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYCLES - 1);

  mon_state_e        r_state, w_state_next;
  logic [IDX_W:0]    r_exp_count, r_mismatch_count, w_exp_count_eff;
  logic [IDX_W-1:0]  r_idx, r_first_fail_idx, w_idx_next;
  logic [CYC_W-1:0]  r_cycle_count, w_cycle_next;
  logic              r_timeout;
  logic              w_run, w_start_run, w_accept, w_last, w_miss, w_timeout_hit, w_end_run;
  logic              w_exp_wr_en;
  logic [DATA_W-1:0] w_exp_rd;

  assign w_run       = (r_state == ST_RUN);
  assign w_start_run = start && !w_run;
  assign w_accept    = w_run && sample_valid;
  assign w_last      = w_accept && ({1'b0, r_idx} == (r_exp_count - CNT_ONE));
  // The expected RAM is addressed one step ahead, so exp[idx] is ready when a sample lands.
  assign w_miss      = w_accept && (sample_data != w_exp_rd);
  assign w_cycle_next  = CYC_W'(sat_inc(32'(r_cycle_count), 32'(CYC_MAX)));
  // A final sample in the timeout cycle wins over the timeout.
  assign w_timeout_hit = w_run && !w_last && (w_cycle_next >= CYC_LIMIT);
  assign w_exp_wr_en   = exp_wr_en && !w_run;

  assign w_exp_count_eff = (exp_count == '0)       ? CNT_ONE   :
                           (exp_count > CNT_DEPTH) ? CNT_DEPTH : exp_count;

`ifdef MONITOR_STOP_ON_FAIL_EN
  assign w_end_run = w_last || w_timeout_hit || w_miss;
`else
  assign w_end_run = w_last || w_timeout_hit;
`endif

  // Index the run will use after this edge; drives the expected-table read address.
  always_comb begin
    w_idx_next = r_idx;
    if (w_start_run)   w_idx_next = '0;
    else if (w_accept) w_idx_next = IDX_W'(sat_inc(32'(r_idx), 32'(DEPTH - 1)));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)     w_state_next = ST_RUN;
      ST_RUN:  if (w_end_run) w_state_next = ST_DONE;
      ST_DONE: if (start)     w_state_next = ST_RUN;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  // Run counters and result flags: cleared on start, updated while running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exp_count      <= '0;
      r_idx            <= '0;
      r_mismatch_count <= '0;
      r_first_fail_idx <= '0;
      r_cycle_count    <= '0;
      r_timeout        <= 1'b0;
    end else if (w_start_run) begin
      r_exp_count      <= w_exp_count_eff;
      r_idx            <= '0;
      r_mismatch_count <= '0;
      r_first_fail_idx <= '0;
      r_cycle_count    <= '0;
      r_timeout        <= 1'b0;
    end else if (w_run) begin
      r_cycle_count <= w_cycle_next;
      r_idx         <= w_idx_next;
      if (w_miss) begin
        r_mismatch_count <= (IDX_W+1)'(sat_inc(32'(r_mismatch_count), 32'(r_exp_count)));
        if (r_mismatch_count == '0) r_first_fail_idx <= r_idx;
      end
      if (w_timeout_hit) r_timeout <= 1'b1;
    end
  end

  monitor_ram #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_exp_ram (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_wr_en   (w_exp_wr_en),
    .i_wr_addr (exp_wr_addr),
    .i_wr_data (exp_wr_data),
    .i_rd_addr (w_idx_next),
    .o_rd_data (w_exp_rd)
  );

  monitor_ram #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_trace_ram (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_idx),
    .i_wr_data (sample_data),
    .i_rd_addr (trace_rd_addr),
    .o_rd_data (trace_rd_data)
  );

  assign busy           = w_run;
  assign done           = (r_state == ST_DONE);
  assign pass           = done && (r_mismatch_count == '0) && !r_timeout;
  assign timeout        = r_timeout;
  assign mismatch_count = r_mismatch_count;
  assign first_fail_idx = r_first_fail_idx;
  assign cycle_count    = r_cycle_count;

endmodule

// File: tb/tb_cpu_result_monitor.sv
// Scoreboard bench for cpu_result_monitor with default parameters
// (DATA_W=16, DEPTH=16, CYC_W=16, MAX_CYCLES=1000).
module tb_cpu_result_monitor;

  logic        clk = 1'b0;
  logic        reset, start, exp_wr_en, sample_valid;
  logic [4:0]  exp_count;
  logic [3:0]  exp_wr_addr, trace_rd_addr;
  logic [15:0] exp_wr_data, sample_data, trace_rd_data;
  logic        busy, done, pass, timeout;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail_idx;
  logic [15:0] cycle_count;

  cpu_result_monitor dut (
    .clk(clk), .reset(reset), .start(start), .exp_count(exp_count),
    .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .trace_rd_addr(trace_rd_addr), .trace_rd_data(trace_rd_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .mismatch_count(mismatch_count), .first_fail_idx(first_fail_idx),
    .cycle_count(cycle_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic        busy, done, pass, tmo;
    logic [4:0]  mm;
    logic [3:0]  ff;
    logic [15:0] cyc;
    logic        chk_rd;
    logic [15:0] rd;
  } res_t;

  typedef struct {
    int          tag;
    logic [15:0] v;
  } rd_t;

  res_t q_res[$];   // popped when done rises
  res_t q_snap[$];  // popped at the next falling edge
  rd_t  q_rd[$];    // popped one cycle after a read strobe

  int   checks = 0;
  int   errors = 0;
  logic rd_req = 1'b0, rd_req_d = 1'b0, done_q = 1'b0, tb_end = 1'b0;

  function automatic res_t mk(input int tag, input int b, input int d, input int p,
                              input int t, input int mm, input int ff, input int cyc,
                              input int chk_rd, input int rd);
    res_t e;
    e.tag = tag; e.busy = 1'(b); e.done = 1'(d); e.pass = 1'(p); e.tmo = 1'(t);
    e.mm = 5'(mm); e.ff = 4'(ff); e.cyc = 16'(cyc); e.chk_rd = 1'(chk_rd); e.rd = 16'(rd);
    return e;
  endfunction

  // ---------------- monitor / checker ----------------
  task automatic chk(input int tag, input string what, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL run%0d %s: got %0h expected %0h", tag, what, act, exp_v);
    end
  endtask

  task automatic chk_res(input res_t e);
    chk(e.tag, "busy",           32'(busy),           32'(e.busy));
    chk(e.tag, "done",           32'(done),           32'(e.done));
    chk(e.tag, "pass",           32'(pass),           32'(e.pass));
    chk(e.tag, "timeout",        32'(timeout),        32'(e.tmo));
    chk(e.tag, "mismatch_count", 32'(mismatch_count), 32'(e.mm));
    chk(e.tag, "first_fail_idx", 32'(first_fail_idx), 32'(e.ff));
    chk(e.tag, "cycle_count",    32'(cycle_count),    32'(e.cyc));
    if (e.chk_rd) chk(e.tag, "trace_rd_data", 32'(trace_rd_data), 32'(e.rd));
  endtask

  initial begin
    rd_t r;
    forever begin
      @(negedge clk);
      while (q_snap.size() > 0) chk_res(q_snap.pop_front());
      if (rd_req_d && q_rd.size() > 0) begin
        r = q_rd.pop_front();
        chk(r.tag, "trace_rd_data", 32'(trace_rd_data), 32'(r.v));
      end
      rd_req_d = rd_req;
      if (done && !done_q) begin
        if (q_res.size() > 0) chk_res(q_res.pop_front());
        else chk(0, "unexpected done", 32'(done), 32'd0);
      end
      done_q = done;
      if (tb_end) begin
        chk(0, "runs never completed", 32'(q_res.size()), 32'd0);
        chk(0, "reads never returned", 32'(q_rd.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp(input int a, input int d);
    exp_wr_en = 1'b1; exp_wr_addr = 4'(a); exp_wr_data = 16'(d);
    tick();
    exp_wr_en = 1'b0;
  endtask

  task automatic do_start(input int n);
    exp_count = 5'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sample(input int d);
    sample_valid = 1'b1; sample_data = 16'(d);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done) break;
      tick();
    end
  endtask

  task automatic read_trace(input int a, input int v, input int tag);
    rd_t r;
    r.tag = tag; r.v = 16'(v);
    trace_rd_addr = 4'(a);
    q_rd.push_back(r);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic expect_done(input int tag, input int p, input int t, input int mm,
                             input int ff, input int cyc);
    q_res.push_back(mk(tag, 0, 1, p, t, mm, ff, cyc, 0, 0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; exp_count = '0; exp_wr_en = 1'b0; exp_wr_addr = '0;
    exp_wr_data = '0; sample_valid = 1'b0; sample_data = '0; trace_rd_addr = '0;
    q_snap.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    load_exp(0, 5); load_exp(1, 10); load_exp(2, 15); load_exp(3, 20);

    // all match, with gaps and an ignored start mid-run: 7 RUN cycles
    expect_done(2, 1, 0, 0, 0, 7);
    do_start(4);
    sample(5);
    start = 1'b1; tick(); start = 1'b0;
    sample(10); idle(2); sample(15); sample(20);
    wait_done(20);
    read_trace(2, 15, 2); read_trace(0, 5, 2); read_trace(3, 20, 2);

    // two mismatches at indices 1 and 3
`ifdef MONITOR_STOP_ON_FAIL_EN
    expect_done(3, 0, 0, 1, 1, 2);
`else
    expect_done(3, 0, 0, 2, 1, 4);
`endif
    do_start(4);
    sample(5); sample(11); sample(15); sample(19);
    wait_done(20);
`ifdef MONITOR_STOP_ON_FAIL_EN
    read_trace(1, 11, 3); read_trace(3, 20, 3);
`else
    read_trace(1, 11, 3); read_trace(3, 19, 3);
`endif

    // only two samples: timeout with cycle_count 999
    expect_done(4, 0, 1, 0, 0, 999);
    do_start(4);
    sample(5); sample(10);
    wait_done(1200);

    // reset mid-run after two samples
`ifdef MONITOR_STOP_ON_FAIL_EN
    expect_done(5, 0, 0, 1, 0, 1);
`endif
    do_start(4);
    sample(7); sample(8);
    reset = 1'b1;
    q_snap.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tick(); tick();
    reset = 1'b0;
    q_snap.push_back(mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    sample_valid = 1'b1; sample_data = 16'hBEEF;   // ignored in IDLE
    tick(); tick();
    sample_valid = 1'b0;
    read_trace(0, 7, 6);
`ifdef MONITOR_STOP_ON_FAIL_EN
    read_trace(1, 10, 6);
`else
    read_trace(1, 8, 6);
`endif

    // clean run after reset
    expect_done(7, 1, 0, 0, 0, 4);
    do_start(4);
    sample(5); sample(10); sample(15); sample(20);
    wait_done(20);

    // final sample on the timeout cycle; table write during RUN is ignored
    expect_done(8, 1, 0, 0, 0, 999);
    do_start(4);
    sample(5); sample(10); sample(15);
    load_exp(3, 16'h1234);
    idle(994);
    sample(20);
    wait_done(20);

    // full depth, all 0xFFFF
    for (int i = 0; i < 16; i++) load_exp(i, 16'hFFFF);
    expect_done(9, 1, 0, 0, 0, 16);
    do_start(16);
    repeat (16) sample(16'hFFFF);
    wait_done(20);
    read_trace(15, 16'hFFFF, 9); read_trace(0, 16'hFFFF, 9);

    // exp_count of 0 behaves as 1
    expect_done(10, 1, 0, 0, 0, 1);
    do_start(0);
    sample(16'hFFFF);
    wait_done(20);

    idle(3);
    tb_end = 1'b1;
    idle(5);
  end

endmodule
